time_bcd_counter: RTL and testbench
===================================

// Module: time_bcd_counter
// PURPOSE
//  Time-of-day keeper feeding the 6-digit seven-segment scan driver. Divides clk to a 1 Hz tick
//  and advances a BCD hh:mm:ss counter. Runs a mode/up button state machine for setting the time.
//  Presents six registered BCD digits (h_ten..s_one) straight to the display driver inputs.
// PARAMETERS
//  CLK_HZ   1000   clk cycles per second; prescaler terminal count = CLK_HZ-1 (bench uses 4)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, asynchronous, active-high
//  btn_mode  in   1  mode button level; already synchronised/debounced; acts on rising edge
//  btn_up    in   1  increment button level; already synchronised/debounced; acts on rising edge
//  h_ten     out  4  hours tens BCD (0-2; 0-1 in 12h)
//  h_one     out  4  hours ones BCD (0-9)
//  m_ten     out  4  minutes tens BCD (0-5)
//  m_one     out  4  minutes ones BCD (0-9)
//  s_ten     out  4  seconds tens BCD (0-5)
//  s_one     out  4  seconds ones BCD (0-9)
//  tick_1hz  out  1  one-cycle pulse on each prescaler terminal count (RUN only)
//  blink     out  3  one-hot field being set: [2]=hh, [1]=mm, [0]=ss; 000 in RUN
//  pm        out  1  PM indicator (12h build only; constant 0 otherwise)
// BEHAVIOUR
//  - Reset: digits 00:00:00, tick_1hz=0, blink=000, pm=0, state RUN, prescaler=0.
//  - Reset: button edge-detect regs reset to 1, so a button held through reset gives no edge.
//  - All outputs are registered. A digit update is visible the cycle after the tick/edge.
//  - Prescaler: in RUN it counts 0..CLK_HZ-1, then wraps to 0. tick_1hz=1 in the cycle count==CLK_HZ-1.
//  - The time advances on that same clock edge.
//  - RUN carry chain: ss 59->00 carries into mm; mm 59->00 carries into hh; 23:59:59 -> 00:00:00.
//  - FSM states: RUN -> SET_H -> SET_M -> SET_S -> RUN, one step per btn_mode rising edge.
//  - In SET_*: prescaler held at 0, no tick, time does not advance.
//  - In SET_*: btn_up edge increments only the selected field, wrapping with no carry:
//    hh 23->00, mm 59->00, ss 59->00.
//  - Leaving SET_S -> RUN: prescaler restarts from 0; first tick after exactly CLK_HZ cycles.
//  - Simultaneous btn_mode and btn_up edges: mode wins, up ignored that cycle.
//  - Button held high: one action only; no auto-repeat.
//  - BCD invariant: no digit ever leaves its legal range, including transient cycles.
//  - Async rst mid-set or mid-count returns everything to reset values immediately.
// CONFIGURATION
//  - CLOCK_12H_EN defined: hours sequence 12,01,...,11,12; reset value 12:00:00 with pm=0.
//  - CLOCK_12H_EN: pm toggles on 11:59:59 -> 12:00:00 in RUN, and on an hh 11->12 increment in SET_H.
//  - CLOCK_12H_EN: h_ten never exceeds 1.
//  - CLOCK_12H_EN undefined: 24h behaviour as above; pm tied to 0.
// STRUCTURE
//  - Package time_pkg: state enum (RUN, SET_H, SET_M, SET_S).
//  - time_pkg constants: SEC_MAX_TEN=5, MIN_MAX_TEN=5, HOUR_MAX_24=23, HOUR_MIN_12=1, HOUR_MAX_12=12.
//  - time_pkg also holds a 4-bit bcd_t typedef.
//  - Sub-module bcd_pair_cnt: two-digit BCD counter, wraps at 59, ports inc/carry_out.
//    Instanced for seconds and minutes.
//  - Hours are handled locally (24h/12h rules).
// TESTING (CLK_HZ=4)
//  - Reset release -> 00:00:00, blink=000; tick_1hz every 4th cycle; s_one=1 after the first tick.
//  - Preload 23:59:58 via set mode, run 2 ticks -> 23:59:59 then 00:00:00 in one cycle, all digits legal.
//  - Mode edge x1, up edge x25 -> blink=100, hh=01 (wrap at 23), mm/ss unchanged.
//  - Ticks during set are suppressed.
//  - Mode+up edges in the same cycle while in SET_M -> state SET_S, mm unchanged.
//  - Exit to RUN -> first tick exactly 4 cycles later.
//  - btn_mode held high through rst deassert -> stays RUN.
//  - Assert rst while in SET_S -> outputs at reset values the same cycle.
//  - CLOCK_12H_EN: from 11:59:59 with pm=0, one tick -> 12:00:00, pm=1.
//  - CLOCK_12H_EN: SET_H, up from 12 -> 01 with pm unchanged.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and limits for the time-of-day keeper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package time_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam int SEC_MAX_TEN = 5;
  localparam int MIN_MAX_TEN = 5;
  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MIN_12 = 1;
  localparam int HOUR_MAX_12 = 12;

  // One-hot field indicator for the display: [2]=hh, [1]=mm, [0]=ss.
  function automatic logic [2:0] blink_of(state_t s);
    logic [2:0] b;
    b = 3'b000;
    case (s)
      SET_H:   b = 3'b100;
      SET_M:   b = 3'b010;
      SET_S:   b = 3'b001;
      default: b = 3'b000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD counter wrapping at <MAX_TEN>9 -> 00; used for seconds and minutes.
// Latency: new value visible the cycle after inc; carry_out is combinational with inc.
// Backpressure: none; every inc pulse is consumed.
module bcd_pair_cnt
  import time_pkg::*;
#(
  parameter int MAX_TEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output bcd_t ten,
  output bcd_t one,
  output logic carry_out
);

  localparam bcd_t TEN_MAX = bcd_t'(MAX_TEN);

  bcd_t ten_q, ten_d;
  bcd_t one_q, one_d;
  logic at_max;

  assign at_max    = (ten_q == TEN_MAX) && (one_q == 4'd9);
  assign carry_out = inc && at_max;
  assign ten       = ten_q;
  assign one       = one_q;

  // Next digit pair: wrap to 00 at the top, otherwise ordinary BCD increment.
  always_comb begin
    ten_d = ten_q;
    one_d = one_q;
    if (inc) begin
      if (at_max) begin
        ten_d = 4'd0;
        one_d = 4'd0;
      end else if (one_q == 4'd9) begin
        ten_d = ten_q + 4'd1;
        one_d = 4'd0;
      end else begin
        one_d = one_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ten_q <= 4'd0;
      one_q <= 4'd0;
    end else begin
      ten_q <= ten_d;
      one_q <= one_d;
    end
  end

endmodule

// File: rtl/time_bcd_counter.sv
// BCD hh:mm:ss time keeper with 1 Hz prescaler and mode/up button time setting.
// Latency: digits/tick/blink/pm registered; a digit update is visible the cycle after the tick or button edge.
// Backpressure: none; button edges act once per rising edge. Build option CLOCK_12H_EN selects 12h hours with pm.
module time_bcd_counter
  import time_pkg::*;
#(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  output bcd_t       h_ten,
  output bcd_t       h_one,
  output bcd_t       m_ten,
  output bcd_t       m_one,
  output bcd_t       s_ten,
  output bcd_t       s_one,
  output logic       tick_1hz,
  output logic [2:0] blink,
  output logic       pm
);

  localparam int               CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

`ifdef CLOCK_12H_EN
  localparam bcd_t H_RST_TEN = bcd_t'(HOUR_MAX_12 / 10);
  localparam bcd_t H_RST_ONE = bcd_t'(HOUR_MAX_12 % 10);
  localparam bcd_t H_MIN_TEN = bcd_t'(HOUR_MIN_12 / 10);
  localparam bcd_t H_MIN_ONE = bcd_t'(HOUR_MIN_12 % 10);
  localparam bcd_t H_PRE_TEN = bcd_t'((HOUR_MAX_12 - 1) / 10);
  localparam bcd_t H_PRE_ONE = bcd_t'((HOUR_MAX_12 - 1) % 10);
`else
  localparam bcd_t H_RST_TEN = 4'd0;
  localparam bcd_t H_RST_ONE = 4'd0;
  localparam bcd_t H_TOP_TEN = bcd_t'(HOUR_MAX_24 / 10);
  localparam bcd_t H_TOP_ONE = bcd_t'(HOUR_MAX_24 % 10);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [2:0]       blink_q, blink_d;
  logic             mode_prev_q, mode_prev_d;
  logic             up_prev_q, up_prev_d;
  bcd_t             h_ten_q, h_ten_d;
  bcd_t             h_one_q, h_one_d;
  logic             pm_q, pm_d;

  logic mode_edge, up_edge, run_next;
  logic sec_inc, min_inc, hour_inc;
  logic sec_carry, min_carry;

  // Mode wins over up when both rise in the same cycle.
  assign mode_edge = btn_mode & ~mode_prev_q;
  assign up_edge   = btn_up & ~up_prev_q & ~mode_edge;

  // tick_q is only ever high in a RUN cycle whose count is at terminal, so it
  // doubles as the "advance time on this edge" strobe.
  assign sec_inc  = tick_q | ((state_q == SET_S) & up_edge);
  assign min_inc  = (tick_q & sec_carry) | ((state_q == SET_M) & up_edge);
  assign hour_inc = (tick_q & sec_carry & min_carry) | ((state_q == SET_H) & up_edge);

  // Mode sequencing, prescaler and tick; prescaler idles at 0 outside RUN.
  always_comb begin
    mode_prev_d = btn_mode;
    up_prev_d   = btn_up;
    state_d     = state_q;
    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end
    blink_d  = blink_of(state_d);
    // Counting only continues across cycles that are RUN on both sides, so
    // re-entering RUN always starts the second from count 0.
    run_next = (state_q == RUN) && (state_d == RUN);
    if (!run_next || cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = run_next && (cnt_d == CNT_MAX);
  end

  // Hours: local increment with 24h or 12h wrap rules; pm flips entering 12.
  always_comb begin
    h_ten_d = h_ten_q;
    h_one_d = h_one_q;
    pm_d    = pm_q;
`ifdef CLOCK_12H_EN
    if (hour_inc) begin
      if (h_ten_q == H_RST_TEN && h_one_q == H_RST_ONE) begin
        h_ten_d = H_MIN_TEN;
        h_one_d = H_MIN_ONE;
      end else if (h_ten_q == H_PRE_TEN && h_one_q == H_PRE_ONE) begin
        h_ten_d = H_RST_TEN;
        h_one_d = H_RST_ONE;
        pm_d    = ~pm_q;
      end else if (h_one_q == 4'd9) begin
        h_ten_d = h_ten_q + 4'd1;
        h_one_d = 4'd0;
      end else begin
        h_one_d = h_one_q + 4'd1;
      end
    end
`else
    pm_d = 1'b0;
    if (hour_inc) begin
      if (h_ten_q == H_TOP_TEN && h_one_q == H_TOP_ONE) begin
        h_ten_d = 4'd0;
        h_one_d = 4'd0;
      end else if (h_one_q == 4'd9) begin
        h_ten_d = h_ten_q + 4'd1;
        h_one_d = 4'd0;
      end else begin
        h_one_d = h_one_q + 4'd1;
      end
    end
`endif
  end

  // Control and hour registers; button history resets high to mask held buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 3'b000;
      mode_prev_q <= 1'b1;
      up_prev_q   <= 1'b1;
      h_ten_q     <= H_RST_TEN;
      h_one_q     <= H_RST_ONE;
      pm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      mode_prev_q <= mode_prev_d;
      up_prev_q   <= up_prev_d;
      h_ten_q     <= h_ten_d;
      h_one_q     <= h_one_d;
      pm_q        <= pm_d;
    end
  end

  bcd_pair_cnt #(.MAX_TEN(SEC_MAX_TEN)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (sec_inc),
    .ten       (s_ten),
    .one       (s_one),
    .carry_out (sec_carry)
  );

  bcd_pair_cnt #(.MAX_TEN(MIN_MAX_TEN)) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (min_inc),
    .ten       (m_ten),
    .one       (m_one),
    .carry_out (min_carry)
  );

  assign h_ten    = h_ten_q;
  assign h_one    = h_one_q;
  assign tick_1hz = tick_q;
  assign blink    = blink_q;
  assign pm       = pm_q;

endmodule

// File: tb/tb_time_bcd_counter.sv
// Bench for time_bcd_counter with CLK_HZ=4: time-of-day model plus directed button scripts.
// Latency: outputs compared every negedge against the model; literal checks pin key moments.
// Backpressure: n/a. Honours CLOCK_12H_EN the same way as the design.
module tb_time_bcd_counter;

  localparam int CLK_HZ = 4;

`ifdef CLOCK_12H_EN
  localparam bit   IS_12H = 1'b1;
  localparam logic [3:0] RST_HT = 4'd1;
  localparam logic [3:0] RST_HO = 4'd2;
`else
  localparam bit   IS_12H = 1'b0;
  localparam logic [3:0] RST_HT = 4'd0;
  localparam logic [3:0] RST_HO = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic       tick_1hz;
  logic [2:0] blink;
  logic       pm;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  time_bcd_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .h_ten    (h_ten),
    .h_one    (h_one),
    .m_ten    (m_ten),
    .m_one    (m_one),
    .s_ten    (s_ten),
    .s_one    (s_one),
    .tick_1hz (tick_1hz),
    .blink    (blink),
    .pm       (pm)
  );

  always #5 clk = ~clk;

  // Model: time held as 24h hour/min/sec integers, mode 0=RUN 1=H 2=M 3=S,
  // cnt = cycles elapsed in the current RUN second.
  typedef struct packed {
    int h24;
    int mn;
    int sc;
    int mode;
    int cnt;
    bit prev_m;
    bit prev_u;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    r.prev_m = 1'b1;
    r.prev_u = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic bm, logic bu);
    mdl_t n;
    bit   me, ue;
    int   t;
    n  = m;
    me = bm && !m.prev_m;
    ue = bu && !m.prev_u && !me;
    if (m.mode == 0 && m.cnt == CLK_HZ - 1) begin
      t    = (m.h24 * 3600 + m.mn * 60 + m.sc + 1) % 86400;
      n.h24 = t / 3600;
      n.mn  = (t / 60) % 60;
      n.sc  = t % 60;
    end
    if (me) begin
      n.mode = (m.mode + 1) % 4;
    end else if (ue) begin
      case (m.mode)
        1: n.h24 = (m.h24 + 1) % 24;
        2: n.mn  = (m.mn + 1) % 60;
        3: n.sc  = (m.sc + 1) % 60;
        default: ;
      endcase
    end
    n.cnt    = (m.mode == 0 && n.mode == 0) ? (m.cnt + 1) % CLK_HZ : 0;
    n.prev_m = bm;
    n.prev_u = bu;
    return n;
  endfunction

  function automatic logic [28:0] mdl_out(mdl_t m);
    int         hd;
    logic       pmv;
    logic [2:0] bl;
    if (IS_12H) begin
      hd  = (m.h24 % 12 == 0) ? 12 : m.h24 % 12;
      pmv = (m.h24 >= 12);
    end else begin
      hd  = m.h24;
      pmv = 1'b0;
    end
    case (m.mode)
      1: bl = 3'b100;
      2: bl = 3'b010;
      3: bl = 3'b001;
      default: bl = 3'b000;
    endcase
    return {4'(hd / 10), 4'(hd % 10), 4'(m.mn / 10), 4'(m.mn % 10),
            4'(m.sc / 10), 4'(m.sc % 10),
            (m.mode == 0 && m.cnt == CLK_HZ - 1), bl, pmv};
  endfunction

  mdl_t mdl;

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= mdl_reset();
    else     mdl <= mdl_step(mdl, btn_mode, btn_up);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model plus a digit-range check.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cycle", 32'({h_ten, h_one, m_ten, m_one, s_ten, s_one, tick_1hz, blink, pm}),
          32'(mdl_out(mdl)));
      chk("legal", 32'((h_ten <= (IS_12H ? 4'd1 : 4'd2)) && h_one <= 4'd9 &&
                       m_ten <= 4'd5 && m_one <= 4'd9 && s_ten <= 4'd5 && s_one <= 4'd9),
          32'd1);
    end
  end

  task automatic press_mode();
    @(negedge clk) btn_mode = 1'b1;
    @(negedge clk) btn_mode = 1'b0;
  endtask

  task automatic press_up(input int n);
    repeat (n) begin
      @(negedge clk) btn_up = 1'b1;
      @(negedge clk) btn_up = 1'b0;
    end
  endtask

  // Counts negedges until tick_1hz is seen; an expired budget is a failure.
  task automatic wait_tick(input string name, input int max_cyc, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (tick_1hz) found = 1'b1;
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [23:0] digits();
    return {h_ten, h_one, m_ten, m_one, s_ten, s_one};
  endfunction

  initial begin
    int n;
    int ticks;
    #1 rst = 1'b1;
    #1 cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_digits", 32'(digits()), 32'({RST_HT, RST_HO, 16'h0}));
    chk("rst_blink", 32'(blink), 32'd0);
    chk("rst_tick_pm", 32'({tick_1hz, pm}), 32'd0);

    // Reset cycle counts as prescaler 0, so first tick is the 3rd negedge after release.
    wait_tick("tick1", 10, n);
    chk("first_tick_gap", 32'(n), 32'd3);
    wait_tick("tick2", 10, n);
    chk("tick_period", 32'(n), 32'd4);
    chk("s_one_after_tick", 32'(s_one), 32'd1);

    // Fresh start, then set mode.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    press_mode();
`ifdef CLOCK_12H_EN
    press_up(1);
    chk("set_h_12_to_01", 32'({blink, digits(), pm}), 32'({3'b100, 24'h010000, 1'b0}));
    press_up(10);
    chk("set_h_11", 32'({h_ten, h_one}), 32'h11);
`else
    press_up(25);
    chk("set_h_wrap", 32'({blink, digits()}), 32'({3'b100, 24'h010000}));
    press_up(22);
    chk("set_h_23", 32'({h_ten, h_one}), 32'h23);
`endif
    press_mode();
    press_up(59);
    chk("set_m_59", 32'({blink, m_ten, m_one}), 32'({3'b010, 8'h59}));

    // Ticks stay suppressed while setting.
    ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
    end
    chk("set_no_tick", 32'(ticks), 32'd0);

    // Mode and up together: mode advances, minutes untouched.
    @(negedge clk) begin btn_mode = 1'b1; btn_up = 1'b1; end
    @(negedge clk) begin btn_mode = 1'b0; btn_up = 1'b0; end
    chk("mode_wins", 32'({blink, m_ten, m_one}), 32'({3'b001, 8'h59}));

`ifdef CLOCK_12H_EN
    press_up(59);
    chk("set_s_59", 32'({s_ten, s_one}), 32'h59);
`else
    press_up(58);
    chk("set_s_58", 32'({s_ten, s_one}), 32'h58);
`endif

    // Exit to RUN: first tick 4 cycles after the mode edge.
    @(negedge clk) btn_mode = 1'b1;
    @(negedge clk) btn_mode = 1'b0;
    wait_tick("exit_tick", 10, n);
    chk("exit_tick_gap", 32'(n + 1), 32'd4);
`ifdef CLOCK_12H_EN
    chk("pre_noon", 32'({digits(), pm}), 32'({24'h115959, 1'b0}));
    @(negedge clk);
    chk("noon_pm", 32'({digits(), pm}), 32'({24'h120000, 1'b1}));
`else
    chk("pre_58", 32'(digits()), 32'h235958);
    wait_tick("tick59", 10, n);
    chk("tick59_gap", 32'(n), 32'd4);
    chk("pre_59", 32'(digits()), 32'h235959);
    @(negedge clk);
    chk("midnight", 32'(digits()), 32'h000000);
`endif

    // Mode held through reset release gives no edge.
    @(negedge clk) begin rst = 1'b1; btn_mode = 1'b1; end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_mode_run", 32'(blink), 32'd0);
    wait_tick("held_tick", 10, n);
    btn_mode = 1'b0;

    // Async reset while in SET_S.
    press_mode();
    press_mode();
    press_mode();
    chk("in_set_s", 32'(blink), 32'b001);
    press_up(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({digits(), tick_1hz, blink, pm}),
        32'({RST_HT, RST_HO, 16'h0, 1'b0, 3'b000, 1'b0}));
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
